// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants and RGB565 pixel definitions shared by the VGA controller and its pixel interface
package vga_timing_pkg;
   localparam int H_SYNC  = 96;
   localparam int H_BACK  = 48;
   localparam int H_VALID = 640;
   localparam int H_FRONT = 16;
   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 33;
   localparam int V_VALID = 480;
   localparam int V_FRONT = 10;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int H_START = H_SYNC + H_BACK;
   localparam int V_START = V_SYNC + V_BACK;
   localparam int RGB_W   = 16;
   localparam logic [RGB_W-1:0] RGB_BLACK = 16'h0000;
endpackage

// File: rtl/vga_ctrl_if.sv
// vga_ctrl_if: pixel request channel between the timing controller (master) and the upstream pixel generator (slave)
//   pix_req/pix_x/pix_y : request for the pixel at (pix_x, pix_y), from the controller
//   pix_data            : RGB565 answer, registered by upstream, valid the cycle after pix_req
interface vga_ctrl_if;
   import vga_timing_pkg::*;
   logic             pix_req;
   logic [9:0]       pix_x;
   logic [9:0]       pix_y;
   logic [RGB_W-1:0] pix_data;
   modport master (output pix_req, pix_x, pix_y, input pix_data);
   modport slave  (input pix_req, pix_x, pix_y, output pix_data);
endinterface

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing controller; free-running h/v counters, one-cycle-early pixel requests and a shared sync/RGB output register
//   sys_clk     : pixel clock
//   sys_rst     : synchronous active-low reset
//   pix         : pixel request channel (master side)
//   frame_start : one-cycle pulse with the first hsync-low cycle of a frame
//   vga_hs/vs   : active-low sync outputs
//   vga_rgb     : RGB565 output, black outside the visible area
module vga_ctrl #(
   parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
   parameter int H_BACK  = vga_timing_pkg::H_BACK,
   parameter int H_VALID = vga_timing_pkg::H_VALID,
   parameter int H_FRONT = vga_timing_pkg::H_FRONT,
   parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
   parameter int V_BACK  = vga_timing_pkg::V_BACK,
   parameter int V_VALID = vga_timing_pkg::V_VALID,
   parameter int V_FRONT = vga_timing_pkg::V_FRONT
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   vga_ctrl_if.master                       pix,
   output logic                             frame_start,
   output logic                             vga_hs,
   output logic                             vga_vs,
   output logic [vga_timing_pkg::RGB_W-1:0] vga_rgb
);
   localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
   localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
   localparam logic [9:0] H_ST   = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_END  = 10'(H_SYNC + H_BACK + H_VALID);
   localparam logic [9:0] V_ST   = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_END  = 10'(V_SYNC + V_BACK + V_VALID);
   localparam logic [9:0] HS_W   = 10'(H_SYNC);
   localparam logic [9:0] VS_W   = 10'(V_SYNC);
   // Requests run one cycle ahead of the visible window so upstream has a cycle to register the pixel.
   localparam logic [9:0] REQ_LO = 10'(H_SYNC + H_BACK - 1);
   localparam logic [9:0] REQ_HI = 10'(H_SYNC + H_BACK + H_VALID - 2);

   logic [9:0]                       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic                             vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
   logic                             frame_start_q, frame_start_d;
   logic [vga_timing_pkg::RGB_W-1:0] vga_rgb_q, vga_rgb_d;
   logic                             h_act, v_act, req;

   always_comb begin
      h_cnt_d       = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
      v_cnt_d       = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      h_act         = h_cnt_q >= H_ST && h_cnt_q < H_END;
      v_act         = v_cnt_q >= V_ST && v_cnt_q < V_END;
      req           = v_act && h_cnt_q >= REQ_LO && h_cnt_q <= REQ_HI;
      vga_hs_d      = h_cnt_q >= HS_W;
      vga_vs_d      = v_cnt_q >= VS_W;
      vga_rgb_d     = (h_act && v_act) ? pix.pix_data : vga_timing_pkg::RGB_BLACK;
      frame_start_d = h_cnt_q == '0 && v_cnt_q == '0;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         vga_hs_q      <= 1'b1;
         vga_vs_q      <= 1'b1;
         vga_rgb_q     <= vga_timing_pkg::RGB_BLACK;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
         vga_rgb_q     <= vga_rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix.pix_req  = req;
   assign pix.pix_x    = req ? h_cnt_q - REQ_LO : '0;
   assign pix.pix_y    = req ? v_cnt_q - V_ST : '0;
   assign vga_hs       = vga_hs_q;
   assign vga_vs       = vga_vs_q;
   assign vga_rgb      = vga_rgb_q;
   assign frame_start  = frame_start_q;
endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA 640x480@60 Hz timing controller running on the 25 MHz pixel clock from the PLL. It generates horizontal and vertical sync, requests pixel data one cycle ahead from the upstream pixel generator (colour bar / image source), and drives the 16-bit RGB565 output that goes to the VGA connector. Sync and RGB leave the block through one shared register stage, so they are aligned.

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width (pixel clocks)
- H_BACK, 48, horizontal back porch
- H_VALID, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_VALID, 480, visible lines
- V_FRONT, 10, vertical front porch

Ports:
- sys_clk  in  1  25 MHz pixel clock; single clock domain
- sys_rst  in  1  reset, synchronous, active-low
- pix_data  in  16  RGB565 pixel from upstream; valid the cycle after pix_req
- pix_req  out  1  request for the pixel at (pix_x, pix_y)
- pix_x  out  10  column 0..639 while pix_req=1, else 0
- pix_y  out  10  row 0..479 while pix_req=1, else 0
- frame_start  out  1  one-cycle pulse, aligned with the first hsync-low cycle of a frame
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_rgb  out  16  RGB565 to DAC; 0 outside the visible area

## Operation
- Derived constants: H_TOTAL = 800, V_TOTAL = 525, H_START = H_SYNC+H_BACK = 144, V_START = V_SYNC+V_BACK = 35.
- h_cnt (10 b) counts 0..H_TOTAL-1 and wraps to 0. v_cnt (10 b) increments only when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
- Count origin: h_cnt=0 / v_cnt=0 is the first cycle of the sync pulse.
- hs_next = 0 iff h_cnt < H_SYNC. vs_next = 0 iff v_cnt < V_SYNC.
- v_act = V_START ≤ v_cnt < V_START+V_VALID.
- h_act = H_START ≤ h_cnt < H_START+H_VALID.
- pix_req is combinational: v_act AND H_START-1 ≤ h_cnt ≤ H_START+H_VALID-2 (143..782).
- pix_x = h_cnt-(H_START-1) and pix_y = v_cnt-V_START while pix_req=1; both are 0 otherwise.
- Registered outputs, updated every cycle:
  - vga_hs ← hs_next
  - vga_vs ← vs_next
  - vga_rgb ← (h_act AND v_act) ? pix_data : 16'h0000
  - frame_start ← (h_cnt==0 AND v_cnt==0)
- Upstream contract: pix_data must be registered by upstream on the clock edge that samples pix_req, so it is stable when h_act is evaluated. There is no back-pressure; the stream is free-running.
- Reset (sys_rst=0 at a sys_clk edge):
  - h_cnt and v_cnt go to 0.
  - vga_hs and vga_vs go to 1.
  - vga_rgb goes to 0 and frame_start to 0.
  - pix_req, pix_x and pix_y follow the counters, so they are 0.
- Reset mid-frame has the same effect: the current frame is abandoned. After release, counting restarts at h_cnt=0, so the first output cycle is hs low with frame_start high.

## Timing
- Latency: counter state → vga_* outputs is 1 cycle. pix_req → matching pixel on vga_rgb is 2 cycles (one upstream register, one output register).
- Line = 800 cycles. vga_hs is low for 96 consecutive cycles per line. Visible RGB spans 640 cycles, starting 144 cycles after the hs falling edge.
- Frame = 525 lines = 420 000 cycles. vga_vs is low for 2 lines (1600 cycles). Its falling edge coincides with a vga_hs falling edge.
- The h_cnt wrap and v_cnt wrap in the same cycle (799/524 → 0/0) are one event. The next output cycle has hs=0, vs=0 and frame_start=1.
- pix_req is never asserted on lines outside v_act, including on the porch lines adjacent to the visible area.
- No combinational path from pix_data to any output.

## Structure
- Shared package vga_timing_pkg holds:
  - The 640x480@60 timing constants (the eight parameters' defaults plus H_TOTAL, V_TOTAL, H_START, V_START).
  - The RGB565 width constant.
  - The black pixel value 16'h0000.
- Single flat module; no sub-module is warranted. Counters, decode and the output register stage fit in roughly 150 lines.

## Test plan
- Reset: hold sys_rst=0 for 5 cycles → vga_hs=1, vga_vs=1, vga_rgb=0, pix_req=0, frame_start=0. The first cycle after release yields frame_start=1 and vga_hs=0.
- Line timing: run 3 lines → hs falling edges exactly 800 cycles apart, hs low for exactly 96 cycles. Each line on v_cnt 35..514 has exactly 640 pix_req cycles, with pix_x running 0..639 consecutively.
- Frame timing: run 2 frames → vs falling edges 420 000 cycles apart, vs low for 1600 cycles. frame_start pulses once per frame. pix_y covers 0..479; no pix_req on the first 35 or last 10 lines.
- Data path: the bench model returns pix_data = {pix_x[4:0], pix_y[5:0], pix_x[4:0]}, registered → each visible vga_rgb equals the model value 2 cycles after its request. vga_rgb=0 during every blanking cycle even when pix_data=16'hFFFF.
- Alignment: the first visible vga_rgb of a line appears exactly 144 cycles after the vga_hs falling edge. The last appears at 783; cycle 784 is 0.
- Reset mid-frame: assert sys_rst=0 for one cycle at v_cnt=200, h_cnt=400 → the next cycle shows idle outputs. After release, frame_start=1 and the full frame timing restarts from zero.
